lut_arbiter: RTL and testbench
==============================

LUT_ARBITER -- requirements
Module: lut_arbiter

Interface
REQ-001 Parameter AW, default 12, SHALL set the LUT address and requester address width.
REQ-002 Parameter DW, default 12, SHALL set the LUT data and read-data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 req0  input  1  SHALL be the voice-0 read request; held high until granted.
REQ-006 addr0  input  AW  SHALL be the voice-0 LUT address, stable while req0 is high.
REQ-007 req1  input  1  SHALL be the voice-1 read request; held high until granted.
REQ-008 addr1  input  AW  SHALL be the voice-1 LUT address, stable while req1 is high.
REQ-009 gnt0  output  1  SHALL signal a voice-0 grant; combinational, same cycle as the request.
REQ-010 gnt1  output  1  SHALL signal a voice-1 grant; combinational.
REQ-011 lut_en  output  1  SHALL be the shared LUT read enable.
REQ-012 lut_addr  output  AW  SHALL be the shared LUT address, driven through a 2:1 mux selected by the grant.
REQ-013 lut_data  input  DW  SHALL be the LUT read data, valid one cycle after lut_en.
REQ-014 rd_data  output  DW  SHALL be the registered read result.
REQ-015 rd_valid  output  1  SHALL pulse high for one cycle per completed read.
REQ-016 rd_id  output  1  SHALL carry the voice index (0/1) that owns rd_data.

Function
REQ-017 Grants SHALL be one-hot or zero: gnt0 & gnt1 never both high.
REQ-018 The grant SHALL follow these rules:
- only req0 high: gnt0
- only req1 high: gnt1
- both high: grant the voice not granted last (round-robin pointer last_id)
- neither high: no grant
REQ-019 Whenever any grant is given, last_id SHALL update to the granted voice on the next edge; otherwise it SHALL hold.
REQ-020 lut_en SHALL equal gnt0 | gnt1.
REQ-021 lut_addr SHALL be addr1 when gnt1 and addr0 otherwise, including idle cycles.
REQ-022 A request SHALL be consumed in the cycle its grant is high; a requester still high the next cycle is a new request.
REQ-023 A two-stage pipeline SHALL track in-flight reads:
- stage 1 (s1_valid, s1_id) captures lut_en and the granted id at grant cycle N
- at the edge ending cycle N+1: rd_data <= lut_data, rd_id <= s1_id, rd_valid <= s1_valid
REQ-024 Latency SHALL be fixed: a grant in cycle N yields rd_valid high in cycle N+2; no back-pressure.
REQ-025 Throughput SHALL be one read per cycle; with both requests continuously high, grants SHALL alternate 0,1,0,1.
REQ-026 rd_data and rd_id SHALL hold their last values while rd_valid is low.
REQ-027 Requests from both voices in consecutive cycles SHALL produce back-to-back rd_valid pulses with correctly ordered rd_id.

Reset
REQ-028 While rst_n is low, the following SHALL be set on each edge: last_id=1 (voice 0 wins the first tie), s1_valid=0, rd_valid=0, rd_data=0, rd_id=0.
REQ-029 During reset, gnt0, gnt1 and lut_en SHALL be forced to 0 regardless of the requests.
REQ-030 Reset asserted mid-operation SHALL discard in-flight reads; no rd_valid for grants issued in or before the reset cycle.
REQ-031 The first grant SHALL be possible in the first cycle with rst_n high.

Verification
REQ-032 Reset release, req0=req1=1, addr0=0x010, addr1=0x020 held -> gnt sequence 0,1,0,1; rd_id 0,1,0,1 starting 2 cycles after the first grant; rd_data matches LUT[0x010]/LUT[0x020].
REQ-033 req0 alone, one cycle, addr0=0xFFF, LUT[0xFFF]=0xABC -> gnt0=1, lut_addr=0xFFF that cycle; rd_valid=1, rd_id=0, rd_data=0xABC two cycles later; single pulse.
REQ-034 Grant voice 1, then idle 3 cycles, then both request -> gnt0 (pointer held at 1 across idle).
REQ-035 Grant issued in cycle N, rst_n low in cycle N+1 -> no rd_valid in N+2; outputs all zero.
REQ-036 No requests for 10 cycles -> lut_en=0, rd_valid=0, rd_data unchanged throughout.
REQ-037 Random req0/req1 for 1000 cycles -> never both grants high; every grant matched by exactly one rd_valid 2 cycles later with correct id/data; no voice waits more than 1 cycle under contention.

Source files
------------

// File: rtl/lut_arbiter.sv
// Two-voice round-robin arbiter in front of a shared single-port LUT.
// Combinational grant, fixed two-cycle read latency, no back-pressure.
module lut_arbiter #(
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          lut_en,
    output logic [AW-1:0] lut_addr,
    input  logic [DW-1:0] lut_data,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_id
);

    logic       last_id;
    logic       s1_id;
    logic [2:1] vld_pipe;

    // On a tie the voice that did not win last time gets the LUT.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0 && req1) begin
                gnt0 = last_id;
                gnt1 = ~last_id;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign lut_en   = gnt0 | gnt1;
    assign lut_addr = gnt1 ? addr1 : addr0;
    assign rd_valid = vld_pipe[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_id  <= 1'b1;
            vld_pipe <= '0;
            s1_id    <= 1'b0;
            rd_data  <= '0;
            rd_id    <= 1'b0;
        end else begin
            if (lut_en)
                last_id <= gnt1;
            vld_pipe <= {vld_pipe[1], lut_en};
            s1_id    <= gnt1;
            // Result registers only move on a completed read, so they hold otherwise.
            if (vld_pipe[1]) begin
                rd_data <= lut_data;
                rd_id   <= s1_id;
            end
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// Scoreboard bench for lut_arbiter: stimulus pushes expected reads, a negedge
// monitor pops them when rd_valid appears.
module tb_lut_arbiter;

    localparam int AW = 12;
    localparam int DW = 12;

    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk, rst_n, req0, req1;
    logic [AW-1:0] addr0, addr1, lut_addr;
    logic [DW-1:0] lut_data, rd_data;
    logic          gnt0, gnt1, lut_en, rd_valid, rd_id;

    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    bit   started = 0;
    logic mlast  = 1'b1;
    logic [DW-1:0] hold_d  = '0;
    logic          hold_id = 1'b0;
    exp_t q[$];

    lut_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .lut_en(lut_en), .lut_addr(lut_addr),
        .lut_data(lut_data), .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] lut_fn(input logic [AW-1:0] a);
        if (a == 12'hFFF) return 12'hABC;
        return DW'(a * 7 + 12'h123);
    endfunction

    // Synchronous ROM: data one cycle after the address.
    always @(posedge clk) lut_data <= lut_fn(lut_addr);

    // Reset sampled at this edge kills every read not yet delivered.
    always @(posedge clk) begin
        if (!rst_n) begin
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
            hold_d  = '0;
            hold_id = 1'b0;
            started = 1;
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            ntests++; nfail++;
            $display("FAIL rd_missing: got none at cycle %0d want id %0d data %h", q[0].due, q[0].id, q[0].data);
            void'(q.pop_front());
        end
        if (rd_valid === 1'b1) begin
            ntests++;
            if (q.size() == 0 || q[0].due != cyc) begin
                nfail++;
                $display("FAIL rd_unexpected: got rd_valid=1 at cycle %0d want 0", cyc);
            end else begin
                e = q.pop_front();
                if (rd_id !== e.id || rd_data !== e.data) begin
                    nfail++;
                    $display("FAIL rd_result: got id %0d data %h want id %0d data %h", rd_id, rd_data, e.id, e.data);
                end
            end
            hold_d  = rd_data;
            hold_id = rd_id;
        end else if (started) begin
            ntests++;
            if (rd_valid !== 1'b0 || rd_data !== hold_d || rd_id !== hold_id) begin
                nfail++;
                $display("FAIL rd_hold: got v%0d id %0d data %h want v0 id %0d data %h", rd_valid, rd_id, rd_data, hold_id, hold_d);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus. xg >= 0 is a hand-computed {gnt1,gnt0}.
    task automatic step(input logic r0, input logic [AW-1:0] a0, input logic r1,
                        input logic [AW-1:0] a1, input logic rst, input int xg,
                        output logic e0, output logic e1);
        exp_t e;
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; rst_n = rst;
        e0 = 1'b0; e1 = 1'b0;
        if (rst) begin
            if (r0 && r1) begin e0 = mlast; e1 = ~mlast; end
            else begin e0 = r0; e1 = r1; end
        end
        #2;
        chk("grant", {gnt1, gnt0, lut_en, 1'b0, lut_addr}, {e1, e0, e0 | e1, 1'b0, (e1 ? a1 : a0)});
        if (gnt0 === 1'b1 && gnt1 === 1'b1) chk("onehot", 2'b11, 2'b00);
        if (xg >= 0) chk("directed_gnt", {30'd0, gnt1, gnt0}, xg);
        if (e0 | e1) begin
            e.due = cyc + 2; e.id = e1; e.data = lut_fn(e1 ? a1 : a0);
            q.push_back(e);
        end
        if (!rst) mlast = 1'b1;
        else if (e0 | e1) mlast = e1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        logic g0, g1;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, g0, g1);
    endtask

    initial begin
        logic g0, g1, p0, p1, r0, r1;
        logic [AW-1:0] a0, a1;
        int w0, w1;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; rst_n = 0;
        @(posedge clk); #1;
        step(1, 12'h111, 1, 12'h222, 0, 0, g0, g1);
        step(0, 0, 0, 0, 0, 0, g0, g1);
        #2;
        chk("reset_outputs", {rd_valid, rd_id, 2'b00, rd_data}, 16'h0000);
        @(posedge clk); #1;

        // Contention from the first cycle out of reset: 0,1,0,1.
        step(1, 12'h010, 1, 12'h020, 1, 1, g0, g1);
        step(1, 12'h010, 1, 12'h020, 1, 2, g0, g1);
        step(1, 12'h010, 1, 12'h020, 1, 1, g0, g1);
        step(1, 12'h010, 1, 12'h020, 1, 2, g0, g1);
        idle(3);

        // Single top-address read.
        step(1, 12'hFFF, 0, 12'h000, 1, 1, g0, g1);
        idle(1);
        #2; chk("req033_data", {rd_valid, rd_id, 2'b00, rd_data}, 16'h8ABC);
        @(posedge clk); #1;
        idle(2);

        // Pointer holds across idle cycles.
        step(0, 12'h000, 1, 12'h055, 1, 2, g0, g1);
        idle(3);
        step(1, 12'h0A0, 1, 12'h0B0, 1, 1, g0, g1);
        idle(3);

        // Reset right after a grant discards the read.
        step(1, 12'h123, 0, 12'h000, 1, 1, g0, g1);
        step(1, 12'h124, 1, 12'h125, 0, 0, g0, g1);
        step(0, 12'h000, 0, 12'h000, 1, 0, g0, g1);
        #2; chk("req035_zero", {rd_valid, rd_id, 2'b00, rd_data}, 16'h0000);
        @(posedge clk); #1;
        step(1, 12'h300, 1, 12'h301, 1, 1, g0, g1);

        idle(10);

        // Random traffic; requesters hold until granted.
        p0 = 0; p1 = 0; a0 = 0; a1 = 0; w0 = 0; w1 = 0;
        for (int i = 0; i < 1000; i++) begin
            r0 = p0 | 1'($urandom);
            r1 = p1 | 1'($urandom);
            if (!p0) a0 = AW'($urandom);
            if (!p1) a1 = AW'($urandom);
            step(r0, a0, r1, a1, 1, -1, g0, g1);
            p0 = r0 & ~g0;
            p1 = r1 & ~g1;
            w0 = p0 ? w0 + 1 : 0;
            w1 = p1 ? w1 + 1 : 0;
            if (w0 > 1 || w1 > 1) chk("starvation", {w1[15:0], w0[15:0]}, 32'h0001_0001);
        end

        idle(4);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
